// File: rtl/pb_timer_pkg.sv
// Shared register map, bit positions and helpers for the pb_multi_timer block.
package pb_timer_pkg;

   // Each channel occupies a 16-port window.
   localparam int WINDOW_SIZE = 16;

   // Register offsets inside a channel window.
   localparam logic [3:0] OFF_RELOAD = 4'd0;   // 0..3, little-endian
   localparam logic [3:0] OFF_COUNT  = 4'd4;   // 4..7, 4 captures the snapshot
   localparam logic [3:0] OFF_CTRL   = 4'd8;
   localparam logic [3:0] OFF_STATUS = 4'd9;

   // CTRL bit positions.
   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IRQ_EN   = 2;

   // STATUS bit positions.
   localparam int STATUS_EXPIRED = 0;

   // Pick one byte out of a zero-extended 32-bit value.
   function automatic logic [7:0] byte_of(input logic [31:0] value, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_of = value[7:0];
         2'd1:    byte_of = value[15:8];
         2'd2:    byte_of = value[23:16];
         2'd3:    byte_of = value[31:24];
         default: byte_of = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/pb_timer_channel.sv
// One down-counting timer channel: RELOAD, live count, coherent COUNT
// snapshot, CTRL and the sticky expiry flag.
module pb_timer_channel
   import pb_timer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_sel,
   input  logic [3:0] i_offset,
   input  logic [7:0] i_data,
   input  logic       i_write,
   input  logic       i_read,
   input  logic       i_tick,
   output logic [7:0] o_rdata,
   output logic       o_irq
);

   localparam int               NBYTES  = WIDTH / 8;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_snap;
   logic             r_enable;
   logic             r_periodic;
   logic             r_irq_en;
   logic             r_expired;

   logic             w_wr;
   logic             w_rd;
   logic             w_ctrl_wr;
   logic             w_status_wr;
   logic             w_snap_rd;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_enable_nxt;
   logic             w_expire;
   logic [31:0]      w_reload32;
   logic [31:0]      w_count32;
   logic [31:0]      w_snap32;
   logic [7:0]       w_rdata;

   assign w_wr        = i_sel & i_write;
   assign w_rd        = i_sel & i_read;
   assign w_ctrl_wr   = w_wr && (i_offset == OFF_CTRL);
   assign w_status_wr = w_wr && (i_offset == OFF_STATUS);
   assign w_snap_rd   = w_rd && (i_offset == OFF_COUNT);

   // Next count/enable: a CTRL write beats the tick, so a disabling write
   // on a tick-at-zero suppresses the expiry.
   always_comb begin
      w_count_nxt  = r_count;
      w_enable_nxt = r_enable;
      w_expire     = 1'b0;
      if (w_ctrl_wr && i_data[CTRL_ENABLE] && !r_enable) begin
         w_enable_nxt = 1'b1;
         w_count_nxt  = r_reload;
      end else if (w_ctrl_wr && !i_data[CTRL_ENABLE]) begin
         w_enable_nxt = 1'b0;
      end else if (i_tick && r_enable) begin
         if (r_count != '0) begin
            w_count_nxt = r_count - CNT_ONE;
         end else begin
            w_expire = 1'b1;
            if (r_periodic) begin
               w_count_nxt = r_reload;
            end else begin
               w_enable_nxt = 1'b0;
            end
         end
      end else begin
         w_count_nxt = r_count;
      end
   end

   // Channel register state; expiry set takes priority over a W1C clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reload   <= '0;
         r_count    <= '0;
         r_snap     <= '0;
         r_enable   <= 1'b0;
         r_periodic <= 1'b0;
         r_irq_en   <= 1'b0;
         r_expired  <= 1'b0;
      end else begin
         r_count  <= w_count_nxt;
         r_enable <= w_enable_nxt;
         if (w_ctrl_wr) begin
            r_periodic <= i_data[CTRL_PERIODIC];
            r_irq_en   <= i_data[CTRL_IRQ_EN];
         end
         if (w_expire) begin
            r_expired <= 1'b1;
         end else if (w_status_wr && i_data[STATUS_EXPIRED]) begin
            r_expired <= 1'b0;
         end
         if (w_snap_rd) begin
            r_snap <= r_count;
         end
         for (int b = 0; b < NBYTES; b++) begin
            if (w_wr && (i_offset == (OFF_RELOAD + 4'(b)))) begin
               r_reload[b*8 +: 8] <= i_data;
            end
         end
      end
   end

   // Zero-extend to 32 bits so bytes above WIDTH read back as 0.
   always_comb begin
      w_reload32            = 32'h0000_0000;
      w_count32             = 32'h0000_0000;
      w_snap32              = 32'h0000_0000;
      w_reload32[WIDTH-1:0] = r_reload;
      w_count32[WIDTH-1:0]  = r_count;
      w_snap32[WIDTH-1:0]   = r_snap;
   end

   // Read mux for this channel; zero when not selected.
   always_comb begin
      w_rdata = 8'h00;
      if (i_sel) begin
         case (i_offset)
            4'd0, 4'd1, 4'd2, 4'd3: w_rdata = byte_of(w_reload32, i_offset[1:0]);
            4'd4:                   w_rdata = byte_of(w_count32, 2'd0);
            4'd5, 4'd6, 4'd7:       w_rdata = byte_of(w_snap32, i_offset[1:0]);
            4'd8: begin
               w_rdata[CTRL_ENABLE]   = r_enable;
               w_rdata[CTRL_PERIODIC] = r_periodic;
               w_rdata[CTRL_IRQ_EN]   = r_irq_en;
            end
            4'd9:                   w_rdata[STATUS_EXPIRED] = r_expired;
            default:                w_rdata = 8'h00;
         endcase
      end else begin
         w_rdata = 8'h00;
      end
   end

   assign o_rdata = w_rdata;
   assign o_irq   = r_expired & r_irq_en;

endmodule

// File: rtl/pb_multi_timer.sv
// Multi-channel Picoblaze timer: shared prescaler, window decode,
// registered read-data OR-mux and interrupt OR over the channels.
module pb_multi_timer
   import pb_timer_pkg::*;
#(
   parameter logic [7:0] BASE_ADDRESS = 8'h20,
   parameter int         N_CHANNELS   = 2,
   parameter int         WIDTH        = 16,
   parameter int         PRESCALE     = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] port_id,
   input  logic [7:0] data_in,
   input  logic       read_strobe,
   input  logic       write_strobe,
   output logic [7:0] data_out,
   output logic       interrupt
);

   localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [8:0]      WIN_SPAN   = 9'(WINDOW_SIZE * N_CHANNELS);

   logic [PW-1:0]         r_presc;
   logic [7:0]            r_data_out;
   logic                  w_tick;
   logic [7:0]            w_rel;
   logic                  w_hit;
   logic [1:0]            w_chan;
   logic [3:0]            w_offset;
   logic [N_CHANNELS-1:0] w_sel;
   logic [7:0]            w_ch_rdata [N_CHANNELS];
   logic [N_CHANNELS-1:0] w_ch_irq;
   logic [7:0]            w_rd_or;
   logic                  w_irq_or;

   // With PRESCALE=1 the counter sits at 0 and tick stays high.
   assign w_tick = (r_presc == PRESC_LAST);

   // Free-running prescaler shared by all channels.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   // Offset-based decode tolerates a base that is not window-aligned.
   assign w_rel    = port_id - BASE_ADDRESS;
   assign w_hit    = ({1'b0, w_rel} < WIN_SPAN);
   assign w_chan   = w_rel[5:4];
   assign w_offset = w_rel[3:0];

   for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
      assign w_sel[c] = w_hit && (w_chan == 2'(c));

      pb_timer_channel #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .i_sel    (w_sel[c]),
         .i_offset (w_offset),
         .i_data   (data_in),
         .i_write  (write_strobe),
         .i_read   (read_strobe),
         .i_tick   (w_tick),
         .o_rdata  (w_ch_rdata[c]),
         .o_irq    (w_ch_irq[c])
      );
   end

   // OR the per-channel read data and interrupt requests.
   always_comb begin
      w_rd_or  = 8'h00;
      w_irq_or = 1'b0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         w_rd_or  = w_rd_or | w_ch_rdata[c];
         w_irq_or = w_irq_or | w_ch_irq[c];
      end
   end

   // Register read data so it follows port_id by one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data_out <= 8'h00;
      end else begin
         r_data_out <= w_rd_or;
      end
   end

   assign data_out  = r_data_out;
   assign interrupt = w_irq_or;

endmodule

// File: tb/tb_pb_multi_timer.sv
// Self-checking bench for pb_multi_timer (2 channels, 16-bit, prescale 4).
module tb_pb_multi_timer;

   localparam logic [7:0] BASE = 8'h20;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] port_id;
   logic [7:0] data_in;
   logic       read_strobe;
   logic       write_strobe;
   logic [7:0] data_out;
   logic       interrupt;

   int n_checks = 0;
   int n_fail   = 0;
   int tcur     = 0;

   logic [7:0] exp_q[$];
   string      name_q[$];

   typedef struct {
      bit         is_wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
      string      nm;
   } vec_t;

   vec_t tbl[26];

   always #5 clk = ~clk;

   pb_multi_timer #(
      .BASE_ADDRESS (BASE),
      .N_CHANNELS   (2),
      .WIDTH        (16),
      .PRESCALE     (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .port_id      (port_id),
      .data_in      (data_in),
      .read_strobe  (read_strobe),
      .write_strobe (write_strobe),
      .data_out     (data_out),
      .interrupt    (interrupt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
      tcur++;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", nm, act, exp, tcur);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      port_id      = a;
      data_in      = d;
      write_strobe = 1'b1;
      cyc();
      write_strobe = 1'b0;
      port_id      = 8'h00;
      data_in      = 8'h00;
   endtask

   // Read: expectation queued at drive time, popped once data_out is registered.
   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
      logic [7:0] e;
      string      n;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      port_id     = a;
      read_strobe = 1'b1;
      cyc();
      read_strobe = 1'b0;
      port_id     = 8'h00;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk(n, {24'h0, data_out}, {24'h0, e});
   endtask

   task automatic adv_to(input int t);
      while (tcur < t) cyc();
   endtask

   task automatic wait_irq(input int budget, output bit ok);
      for (int i = 0; i < budget && !interrupt; i++) cyc();
      ok = interrupt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit seen;
      int te;
      int exp_rise;

      tbl[0]  = '{1'b1, 8'h20, 8'h34, 8'h00, "w_rld0_b0"};
      tbl[1]  = '{1'b1, 8'h21, 8'h12, 8'h00, "w_rld0_b1"};
      tbl[2]  = '{1'b1, 8'h22, 8'hAA, 8'h00, "w_rld0_b2"};
      tbl[3]  = '{1'b1, 8'h23, 8'hBB, 8'h00, "w_rld0_b3"};
      tbl[4]  = '{1'b1, 8'h30, 8'h56, 8'h00, "w_rld1_b0"};
      tbl[5]  = '{1'b1, 8'h1F, 8'hFF, 8'h00, "w_unaddr_1f"};
      tbl[6]  = '{1'b1, 8'h2A, 8'hFF, 8'h00, "w_rsvd_2a"};
      tbl[7]  = '{1'b1, 8'h40, 8'hFF, 8'h00, "w_beyond_40"};
      tbl[8]  = '{1'b1, 8'h28, 8'hF8, 8'h00, "w_ctrl0_rsvd"};
      tbl[9]  = '{1'b1, 8'h38, 8'h06, 8'h00, "w_ctrl1"};
      tbl[10] = '{1'b0, 8'h20, 8'h00, 8'h34, "rld0_b0"};
      tbl[11] = '{1'b0, 8'h21, 8'h00, 8'h12, "rld0_b1"};
      tbl[12] = '{1'b0, 8'h22, 8'h00, 8'h00, "rld0_b2_absent"};
      tbl[13] = '{1'b0, 8'h23, 8'h00, 8'h00, "rld0_b3_absent"};
      tbl[14] = '{1'b0, 8'h30, 8'h00, 8'h56, "rld1_b0"};
      tbl[15] = '{1'b0, 8'h31, 8'h00, 8'h00, "rld1_b1"};
      tbl[16] = '{1'b0, 8'h1F, 8'h00, 8'h00, "unaddr_1f"};
      tbl[17] = '{1'b0, 8'h2A, 8'h00, 8'h00, "rsvd_2a"};
      tbl[18] = '{1'b0, 8'h40, 8'h00, 8'h00, "beyond_40"};
      tbl[19] = '{1'b0, 8'h28, 8'h00, 8'h00, "ctrl0_rsvd_bits"};
      tbl[20] = '{1'b0, 8'h38, 8'h00, 8'h06, "ctrl1_rw"};
      tbl[21] = '{1'b0, 8'h29, 8'h00, 8'h00, "status0_idle"};
      tbl[22] = '{1'b0, 8'h24, 8'h00, 8'h00, "count0_idle"};
      tbl[23] = '{1'b0, 8'h27, 8'h00, 8'h00, "count0_b3_absent"};
      tbl[24] = '{1'b1, 8'h38, 8'h00, 8'h00, "w_ctrl1_clr"};
      tbl[25] = '{1'b0, 8'h38, 8'h00, 8'h00, "ctrl1_cleared"};

      reset        = 1'b1;
      port_id      = 8'h00;
      data_in      = 8'h00;
      read_strobe  = 1'b0;
      write_strobe = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      chk("reset_data_out", {24'h0, data_out}, 32'h0);
      chk("reset_irq", {31'h0, interrupt}, 32'h0);

      // Register map, reserved and unaddressed ports.
      for (int i = 0; i < 26; i++) begin
         if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
         else              rd(tbl[i].addr, tbl[i].exp, tbl[i].nm);
      end

      // Periodic channel 0: RELOAD=5 -> expiry every 24 clks.
      wr(8'h20, 8'h05);
      wr(8'h21, 8'h00);
      wr(8'h28, 8'h07);
      wait_irq(100, ok);
      chk("periodic_first_expiry_seen", {31'h0, ok}, 32'h1);
      tcur = 0;                                   // ticks now land on tcur%4==0
      rd(8'h24, 8'h05, "count_after_reload");     // t=1
      wr(8'h29, 8'h01);                           // t=2
      chk("w1c_clears_irq", {31'h0, interrupt}, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         adv_to(4 * k);
         rd(8'h24, 8'(5 - k), "count_seq");
      end
      wait_irq(20, ok);
      chk("periodic_expiry_timeout", {31'h0, ok}, 32'h1);
      chk("period_24_clks", tcur, 24);
      rd(8'h29, 8'h01, "status0_set");            // t=25
      rd(8'h24, 8'h05, "count_reloaded");         // t=26

      // RELOAD change while running applies at the next reload; W1C vs expiry.
      wr(8'h20, 8'h00);                           // t=27
      wr(8'h29, 8'h01);                           // t=28
      chk("w1c_clear_again", {31'h0, interrupt}, 32'h0);
      adv_to(48);
      chk("expiry_old_reload_period", {31'h0, interrupt}, 32'h1);
      wr(8'h29, 8'h01);                           // t=49
      chk("w1c_off_tick", {31'h0, interrupt}, 32'h0);
      adv_to(51);
      wr(8'h29, 8'h01);                           // t=52, expiry tick
      chk("w1c_vs_expiry_set_wins", {31'h0, interrupt}, 32'h1);
      wr(8'h29, 8'h01);                           // t=53
      chk("w1c_after_coincide", {31'h0, interrupt}, 32'h0);

      // Disabling CTRL write on a tick-at-zero: no expiry.
      adv_to(55);
      wr(8'h28, 8'h04);                           // t=56, irq_en kept, enable off
      chk("disable_vs_tick_no_expiry", {31'h0, interrupt}, 32'h0);
      rd(8'h29, 8'h00, "status0_after_disable");
      rd(8'h28, 8'h04, "ctrl0_after_disable");
      adv_to(64);
      chk("disabled_stays_quiet", {31'h0, interrupt}, 32'h0);

      // One-shot channel 1: RELOAD=2 -> interrupt after 3 ticks.
      wr(8'h30, 8'h02);
      wr(8'h31, 8'h00);
      wr(8'h38, 8'h05);
      te       = tcur;
      exp_rise = (te / 4 + 1) * 4 + 8;
      wait_irq(30, ok);
      chk("oneshot_expiry_timeout", {31'h0, ok}, 32'h1);
      chk("oneshot_rise_time", tcur, exp_rise);
      rd(8'h38, 8'h04, "oneshot_enable_selfclear");
      rd(8'h34, 8'h00, "oneshot_count_zero");
      rd(8'h39, 8'h01, "oneshot_status");
      wr(8'h39, 8'h01);
      chk("oneshot_w1c", {31'h0, interrupt}, 32'h0);
      seen = 1'b0;
      repeat (24) begin
         cyc();
         if (interrupt) seen = 1'b1;
      end
      chk("oneshot_no_reexpiry", {31'h0, seen}, 32'h0);
      rd(8'h39, 8'h00, "oneshot_status_stays_clear");
      rd(8'h34, 8'h00, "oneshot_count_stays_zero");

      // Coherent COUNT read across a decrement that changes the high byte.
      wr(8'h20, 8'h00);
      wr(8'h21, 8'h12);
      while (tcur % 4 != 0) cyc();
      wr(8'h28, 8'h01);                           // loads 0x1200
      rd(8'h24, 8'h00, "coh_lo_first");
      rd(8'h25, 8'h12, "coh_hi_first");
      cyc();                                      // tick: 0x11FF
      rd(8'h25, 8'h12, "coh_hi_snapshot_held");
      rd(8'h24, 8'hFF, "coh_lo_after_dec");
      rd(8'h25, 8'h11, "coh_hi_new_snapshot");
      rd(8'h26, 8'h00, "coh_b2_absent");          // tick: 0x11FE
      rd(8'h27, 8'h00, "coh_b3_absent");
      wr(8'h28, 8'h01);                           // already enabled
      rd(8'h24, 8'hFE, "enable_rewrite_no_reload");

      // Reset in the middle of a running count with interrupt asserted.
      wr(8'h28, 8'h00);
      wr(8'h20, 8'h03);
      wr(8'h21, 8'h00);
      wr(8'h28, 8'h07);
      wait_irq(40, ok);
      chk("pre_reset_irq_timeout", {31'h0, ok}, 32'h1);
      port_id = 8'h28;
      cyc();
      chk("pre_reset_data_out", {24'h0, data_out}, 32'h7);
      reset = 1'b1;
      cyc();
      reset   = 1'b0;
      port_id = 8'h00;
      chk("reset_mid_irq", {31'h0, interrupt}, 32'h0);
      chk("reset_mid_data_out", {24'h0, data_out}, 32'h0);
      rd(8'h20, 8'h00, "rst_rld0");
      rd(8'h24, 8'h00, "rst_count0");
      rd(8'h25, 8'h00, "rst_snap0");
      rd(8'h28, 8'h00, "rst_ctrl0");
      rd(8'h29, 8'h00, "rst_status0");
      rd(8'h30, 8'h00, "rst_rld1");
      rd(8'h38, 8'h00, "rst_ctrl1");
      seen = 1'b0;
      repeat (40) begin
         cyc();
         if (interrupt) seen = 1'b1;
      end
      chk("rst_no_expiry_after", {31'h0, seen}, 32'h0);
      rd(8'h29, 8'h00, "rst_status0_after_wait");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
